// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : RV32i instruction fetch front end. Holds the fetch PC, issues
//               in-order word reads to instruction memory and buffers the
//               returned words, tagged with their PCs, in a small FIFO that
//               feeds the decoder. A taken branch/jump (pc_SEL) reloads the
//               PC, flushes the buffer and discards every read still in
//               flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC         fetch PC loaded on reset
//   FIFO_DEPTH       buffer entries (power of 2, >= 2); also the maximum
//                    number of imem reads in flight
// Ports
//   clk              in   1   clock, all state on rising edge
//   reset            in   1   synchronous, active-high
//   imem_req_valid   out  1   read request valid
//   imem_req_ready   in   1   imem accepts request
//   imem_req_addr    out  32  word address of request (bits[1:0] = 00)
//   imem_resp_valid  in   1   read data valid (in order)
//   imem_resp_data   in   32  read data
//   pc_SEL           in   1   redirect: take redirect_target this cycle
//   redirect_target  in   32  new PC
//   inst             out  32  instruction at buffer head; NOP when empty
//   inst_pc          out  32  PC of inst; 0 when empty
//   inst_valid       out  1   buffer non-empty
//   inst_ready       in   1   decoder consumes head
//   misaligned_err   out  1   one-cycle pulse after a misaligned redirect
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        pc_SEL,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        misaligned_err
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0] c_nop     = 32'h0000_0013;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic [31:0]      resp_pc_q,     resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q,        drop_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic             mis_q,         mis_d;

    logic [31:0]      data_q [FIFO_DEPTH];
    logic [31:0]      pc_q   [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic [CNT_W:0] w_credit_used;
    logic           w_req_fire;
    logic           w_resp_fire;
    logic           w_drop_any;
    logic           w_push;
    logic           w_pop;

    // Buffer slots are reserved at request time: a read is only issued when
    // every in-flight read plus every buffered word still fits, so a response
    // always finds a free slot and needs no backpressure.
    assign w_credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = !reset && !pc_SEL && (w_credit_used < c_depth);
    assign imem_req_addr  = fetch_pc_q;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_fire = imem_resp_valid && !reset;
    assign w_drop_any  = (drop_q != '0);
    // A response landing in a redirect cycle belongs to the old stream.
    assign w_push      = w_resp_fire && !w_drop_any && !pc_SEL;

    assign inst_valid  = !reset && (count_q != '0);
    assign w_pop       = inst_valid && inst_ready && !pc_SEL;

    assign inst           = inst_valid ? data_q[rd_ptr_q] : c_nop;
    assign inst_pc        = inst_valid ? pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign misaligned_err = mis_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(w_req_fire) - CNT_W'(w_resp_fire);
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mis_d         = 1'b0;

        if (pc_SEL) begin
            fetch_pc_d = {redirect_target[31:2], 2'b00};
            resp_pc_d  = {redirect_target[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Nothing is issued this cycle, so every read still in flight
            // after this cycle's response belongs to the abandoned stream.
            if (outstanding_q == '0) begin
                drop_d = '0;
            end else begin
                drop_d = outstanding_q - CNT_W'(w_resp_fire);
            end
            mis_d = |redirect_target[1:0];
        end else begin
            if (w_req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_resp_fire && w_drop_any) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (w_push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            mis_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mis_q         <= mis_d;
        end
    end

    // Buffer storage carries no reset; count_q alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            data_q[wr_ptr_q] <= imem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule
`default_nettype wire
